// File: rtl/des_round_ctrl_if.sv
// Control bundle between the DES round sequencer and its requester,
// consumer and shared round datapath.
interface des_round_ctrl_if;
  logic       in_valid;
  logic       in_ready;
  logic       decrypt;
  logic       load;
  logic       round_en;
  logic [3:0] round_idx;
  logic [1:0] key_shift;
  logic       key_dir;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  // Sequencer side
  modport master (
    input  in_valid, decrypt, out_ready,
    output in_ready, load, round_en, round_idx, key_shift, key_dir,
           out_valid, busy
  );

  // Requester / consumer / datapath side
  modport slave (
    output in_valid, decrypt, out_ready,
    input  in_ready, load, round_en, round_idx, key_shift, key_dir,
           out_valid, busy
  );
endinterface

// File: rtl/des_round_ctrl.sv
// Iterative DES round sequencer: accepts one block, steps the shared round
// datapath through ROUNDS rounds of RND_CYCLES cycles each, supplies the
// key-schedule rotation per round and holds the result until it is taken.
module des_round_ctrl #(
  parameter int unsigned ROUNDS     = 16,
  parameter int unsigned RND_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  des_round_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  localparam logic [3:0] LAST_RND = 4'(ROUNDS - 1);
  localparam logic [3:0] LAST_CYC = 4'(RND_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] round_idx_q, round_idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic       key_dir_q, key_dir_d;

  logic       in_ready, load, round_en, out_valid, busy;
  logic [1:0] key_shift;

  // State and round/cycle counters; reset abandons any in-flight block
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      round_idx_q <= '0;
      cnt_q       <= '0;
      key_dir_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      round_idx_q <= round_idx_d;
      cnt_q       <= cnt_d;
      key_dir_q   <= key_dir_d;
    end
  end

  // Next-state and handshake/round controls
  always_comb begin
    state_d     = state_q;
    round_idx_d = round_idx_q;
    cnt_d       = cnt_q;
    key_dir_d   = key_dir_q;
    in_ready    = 1'b0;
    load        = 1'b0;
    round_en    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b0;
    unique case (state_q)
      IDLE: begin
        // rst gates in_ready so nothing is loaded while reset is asserted
        in_ready = ~rst;
        load     = bus.in_valid & ~rst;
        if (load) begin
          key_dir_d   = bus.decrypt;
          round_idx_d = '0;
          cnt_d       = '0;
          state_d     = ROUND;
        end
      end
      ROUND: begin
        busy = 1'b1;
        if (cnt_q == LAST_CYC) begin
          round_en = 1'b1;
          cnt_d    = '0;
          if (round_idx_q == LAST_RND) begin
            state_d = DONE;
          end else begin
            round_idx_d = round_idx_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (bus.out_ready) begin
          state_d     = IDLE;
          round_idx_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Per-round key rotation; decryption skips the round-0 rotation
  always_comb begin
    key_shift = 2'd0;
    if (state_q == ROUND) begin
      unique case (round_idx_q)
        4'd0:              key_shift = key_dir_q ? 2'd0 : 2'd1;
        4'd1, 4'd8, 4'd15: key_shift = 2'd1;
        default:           key_shift = 2'd2;
      endcase
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.load      = load;
  assign bus.round_en  = round_en;
  assign bus.round_idx = round_idx_q;
  assign bus.key_shift = key_shift;
  assign bus.key_dir   = key_dir_q;
  assign bus.out_valid = out_valid;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_des_round_ctrl.sv
// Bench for des_round_ctrl: a default instance and a short 4-round,
// 3-cycle-per-round instance, checked cycle by cycle against a timing and
// key-schedule reference derived from the block's documented behaviour.
module tb_des_round_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  des_round_ctrl_if bus ();
  des_round_ctrl_if bus2 ();

  des_round_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  des_round_ctrl #(.ROUNDS(4), .RND_CYCLES(3)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  logic sel   = 1'b0;
  logic iv    = 1'b0;
  logic dec_i = 1'b0;
  logic ordy  = 1'b1;

  assign bus.in_valid   = iv & ~sel;
  assign bus2.in_valid  = iv & sel;
  assign bus.decrypt    = dec_i;
  assign bus2.decrypt   = dec_i;
  assign bus.out_ready  = ordy;
  assign bus2.out_ready = ordy;

  logic       o_in_ready, o_load, o_round_en, o_key_dir, o_out_valid, o_busy;
  logic [3:0] o_round_idx;
  logic [1:0] o_key_shift;
  assign o_in_ready  = sel ? bus2.in_ready  : bus.in_ready;
  assign o_load      = sel ? bus2.load      : bus.load;
  assign o_round_en  = sel ? bus2.round_en  : bus.round_en;
  assign o_round_idx = sel ? bus2.round_idx : bus.round_idx;
  assign o_key_shift = sel ? bus2.key_shift : bus.key_shift;
  assign o_key_dir   = sel ? bus2.key_dir   : bus.key_dir;
  assign o_out_valid = sel ? bus2.out_valid : bus.out_valid;
  assign o_busy      = sel ? bus2.busy      : bus.busy;

  int unsigned tests = 0;
  int unsigned fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // DES key schedule: encrypt rotates left 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1;
  // decrypt rotates right with no shift before the first round.
  function automatic int unsigned ref_shift(input bit d, input int unsigned r);
    if (r == 0) return d ? 0 : 1;
    if (r == 1 || r == 8 || r == 15) return 1;
    return 2;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_load"},      o_load,      0);
    chk({tag, "_in_ready"},  o_in_ready,  0);
    chk({tag, "_round_en"},  o_round_en,  0);
    chk({tag, "_round_idx"}, o_round_idx, 0);
    chk({tag, "_key_shift"}, o_key_shift, 0);
    chk({tag, "_key_dir"},   o_key_dir,   0);
    chk({tag, "_out_valid"}, o_out_valid, 0);
    chk({tag, "_busy"},      o_busy,      0);
  endtask

  // Idle cycles; entered and left just after a rising edge
  task automatic idle(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      iv = 1'b0;
      @(negedge clk);
      chk("idle_ready", o_in_ready,  1);
      chk("idle_load",  o_load,      0);
      chk("idle_busy",  o_busy,      0);
      chk("idle_valid", o_out_valid, 0);
      chk("idle_en",    o_round_en,  0);
      chk("idle_shift", o_key_shift, 0);
      @(posedge clk);
      #1;
    end
  endtask

  // One complete block: entered just after a rising edge with the
  // controller idle; left just after the output-handshake edge.
  task automatic run_block(input bit d, input int unsigned hold, input bit next_iv,
                           input int unsigned R, input int unsigned RC);
    int unsigned npulse;
    int unsigned sum;
    bit          exp_en;
    int unsigned exp_idx;
    npulse = 0;
    sum    = 0;
    iv     = 1'b1;
    dec_i  = d;
    ordy   = (hold == 0);
    @(negedge clk);
    chk("accept_ready", o_in_ready, 1);
    chk("accept_load",  o_load,     1);
    @(posedge clk);
    #1;
    iv    = 1'($urandom_range(0, 1));
    dec_i = ~d;
    for (int unsigned c = 0; c <= R * RC; c++) begin
      @(negedge clk);
      exp_en  = (c < R * RC) && ((c % RC) == RC - 1);
      exp_idx = (c < R * RC) ? c / RC : R - 1;
      chk("busy",       o_busy,      1);
      chk("ready_busy", o_in_ready,  0);
      chk("load_busy",  o_load,      0);
      chk("round_en",   o_round_en,  exp_en);
      chk("round_idx",  o_round_idx, exp_idx);
      chk("key_dir",    o_key_dir,   d);
      chk("out_valid",  o_out_valid, c == R * RC);
      chk("key_shift",  o_key_shift, (c < R * RC) ? ref_shift(d, exp_idx) : 0);
      if (o_round_en) begin
        npulse++;
        sum += o_key_shift;
      end
      if (c < R * RC) begin
        @(posedge clk);
        #1;
        iv = 1'($urandom_range(0, 1));
      end
    end
    chk("round_en_count", npulse, R);
    if (R == 16 && !d) chk("enc_shift_sum", sum, 28);
    for (int unsigned h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      iv = 1'b1;
      if (h == hold - 1) ordy = 1'b1;
      @(negedge clk);
      chk("hold_valid", o_out_valid, 1);
      chk("hold_busy",  o_busy,      1);
      chk("hold_idx",   o_round_idx, R - 1);
      chk("hold_en",    o_round_en,  0);
      chk("hold_load",  o_load,      0);
    end
    iv = 1'b1;
    #1;
    chk("handshake_load",  o_load,     0);
    chk("handshake_ready", o_in_ready, 0);
    @(posedge clk);
    #1;
    iv = next_iv;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit b2b;
    b2b = 1'b0;

    // Reset values on both instances, with a request pending
    iv = 1'b1;
    #3;
    sel = 1'b0; #0 chk_reset_vals("rst0");
    sel = 1'b1; #0 chk_reset_vals("rst0b");
    sel = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    iv  = 1'b0;
    @(posedge clk);
    #1;
    idle(1);

    // Encrypt, decrypt, output backpressure on the default instance
    run_block(1'b0, 0, 1'b0, 16, 1);
    idle(1);
    run_block(1'b1, 0, 1'b0, 16, 1);
    idle(2);
    run_block(1'b0, 5, 1'b0, 16, 1);
    idle(1);

    // Short instance: four rounds of three cycles each
    sel = 1'b1;
    run_block(1'b0, 0, 1'b0, 4, 3);
    idle(1);
    run_block(1'b1, 2, 1'b0, 4, 3);
    idle(1);
    sel = 1'b0;

    // Asynchronous reset in round 7 of a decrypt block
    iv    = 1'b1;
    dec_i = 1'b1;
    @(posedge clk);
    #1;
    iv = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("pre_rst_idx", o_round_idx, 7);
    chk("pre_rst_dir", o_key_dir,   1);
    #2;
    iv  = 1'b1;
    rst = 1'b1;
    #1;
    chk_reset_vals("rst_mid");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    iv  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post_rst_valid", o_out_valid, 0);
      chk("post_rst_busy",  o_busy,      0);
      chk("post_rst_en",    o_round_en,  0);
      chk("post_rst_ready", o_in_ready,  1);
    end
    @(posedge clk);
    #1;
    run_block(1'b0, 0, 1'b0, 16, 1);
    idle(1);

    // Back-to-back: second load one cycle after the first handshake
    run_block(1'b0, 0, 1'b1, 16, 1);
    run_block(1'b1, 0, 1'b0, 16, 1);
    idle(1);

    // Randomised blocks across both instances
    for (int n = 0; n < 10; n++) begin
      if (!b2b) sel = 1'($urandom_range(0, 1));
      b2b = 1'($urandom_range(0, 1));
      if (sel)
        run_block(1'($urandom_range(0, 1)), $urandom_range(0, 5), b2b, 4, 3);
      else
        run_block(1'($urandom_range(0, 1)), $urandom_range(0, 5), b2b, 16, 1);
      if (!b2b) idle($urandom_range(1, 3));
    end
    if (b2b) begin
      if (sel) run_block(1'b0, 0, 1'b0, 4, 3);
      else     run_block(1'b0, 0, 1'b0, 16, 1);
    end
    idle(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
